matrix_rx: RTL and testbench
============================

Name: matrix_rx

Overview:
- Receive-side model of the 4-chip 74HC595 chain on the 8x8 RGB matrix board.
- Oversamples matrix_clk, matrix_latch and matrix_mosi in the clk_25mhz domain and shifts a 32-bit word.
- On each latch, transfers the word to an output register, decodes the row, updates an 8-row frame buffer and flags protocol errors.
- Used as an on-FPGA loopback monitor and as the checker end for the matrix driver.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on each serial input (minimum 2).
- WORD_BITS, 32, shift-chain length; fixed 32 for this board (8 red, 8 blue, 8 green, 8 row anode).

Ports:
- clk_25mhz  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- matrix_clk  in  1  serial shift clock from the driver.
- matrix_latch  in  1  latch (CE) from the driver.
- matrix_mosi  in  1  serial data from the driver.
- err_clr  in  1  one-cycle pulse; clears the sticky error flags.
- fb_rd_row  in  3  frame buffer read address.
- fb_rd_data  out  24  {red[7:0], blue[7:0], green[7:0]} for fb_rd_row, active-high, registered.
- latch_word  out  32  last latched raw word.
- word_valid  out  1  one-cycle pulse per latch edge.
- row_index  out  3  row of the last valid row update.
- frame_done  out  1  one-cycle pulse on a valid update of row 7.
- err_bit_count  out  1  sticky: a latch occurred with bit count != 32.
- err_row_onehot  out  1  sticky: anode byte was neither one-hot, 0x00, nor part of the all-ones clear word.
- err_row_seq  out  1  sticky: a valid row arrived that was not (previous row + 1) mod 8.

Behaviour:
- Reset (rst_n low at a clk_25mhz edge):
  - All outputs go to 0. Frame buffer is cleared to 0. Bit counter is 0. The shift register is 0.
  - Edge-detect history is loaded from the current synchronised inputs, so no false edge fires on reset release.
  - Row-sequence tracking is set to "no previous row".
- Input conditioning:
  - Each input passes through SYNC_STAGES flops, then one history flop.
  - A rise is synced==1 with history==0.
  - Serial high and low phases must each last at least 2 clk_25mhz cycles. The driver's fastest setting (4-cycle period) is supported.
- Shift:
  - On a matrix_clk rise: sr <= {sr[30:0], mosi_synced}. mosi is taken from the same sync stage as the clock, so skew is equal.
  - bit_cnt increments and saturates at 63.
- Bit mapping after 32 shifts (first bit shifted in lands at [31]):
  - red col c = ~sr[31-c]
  - blue col c = ~sr[23-c]
  - green col c = ~sr[15-c]
  - anode row k = sr[7-k]
  - Colours are active-low on the wire and stored active-high.
- Latch (matrix_latch rise), 1-cycle latency to outputs:
  - latch_word <= sr; word_valid pulses.
  - If bit_cnt != 32: set err_bit_count and skip the frame update.
  - bit_cnt returns to 0, except when a matrix_clk rise occurs in the same cycle; then the bit is shifted in and bit_cnt <= 1.
- Decode, applied only when bit_cnt == 32:
  - sr == 32'hFFFF_FFFF (driver's power-on clear): all frame rows cleared to 0; no error; row tracking reset.
  - Anode byte 0x00: blank word; no update.
  - Anode byte one-hot at row k: fb[k] <= decoded colours; row_index <= k.
    - If a previous row exists and k != (prev+1) mod 8, set err_row_seq.
    - If k == 7, frame_done pulses in the same cycle as word_valid.
  - Any other anode value: set err_row_onehot; no update.
- Frame buffer read: fb_rd_data is registered with 1-cycle latency. On a same-cycle write to the same row, the old data is returned.
- Errors: sticky until err_clr or reset. If err_clr coincides with a new error, the new error wins (flag ends up set).
- Reset mid-word: the partial shift is discarded and counting restarts from 0.

Test Plan:
- Clear word: shift 32 ones, then latch → latch_word=32'hFFFF_FFFF; word_valid 1 cycle; frame buffer reads all 0; no error flags.
- Row write: shift red byte 0xAA (wire order col0..7 = 1,0,1,0,1,0,1,0), blue 0xFF, green 0xFF, anode one-hot row 2 (sr[5]=1), then latch → row_index=2; fb_rd_row=2 returns 24'h55_00_00 after 1 cycle.
- Row sequence: valid rows 0..7 in order → frame_done pulses once, on row 7, with no error. Then send row 3 → err_row_seq=1; err_clr → 0.
- Count error: 31 clocks, then latch → err_bit_count=1; frame buffer unchanged; word_valid still pulses.
- Anode 0x81 with 32 bits → err_row_onehot=1; no update. Repeat with anode 0x00 → no error and no update.
- Timing and reset: drive at 4-cycle serial period (2 high, 2 low) over 8 rows → all rows are captured correctly. Assert rst_n low after 10 bits, release, then send a full row-0 word → correct capture with no err_bit_count.

Source files
------------

// File: rtl/matrix_rx.sv
// Receive-side model of the four-chip 74HC595 chain on the 8x8 RGB matrix board.
// Oversamples the serial lines, rebuilds each latched 32-bit word and keeps a decoded 8-row frame buffer.
module matrix_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = 32
) (
  input  logic        clk_25mhz,
  input  logic        rst_n,
  input  logic        matrix_clk,
  input  logic        matrix_latch,
  input  logic        matrix_mosi,
  input  logic        err_clr,
  input  logic [2:0]  fb_rd_row,
  output logic [23:0] fb_rd_data,
  output logic [31:0] latch_word,
  output logic        word_valid,
  output logic [2:0]  row_index,
  output logic        frame_done,
  output logic        err_bit_count,
  output logic        err_row_onehot,
  output logic        err_row_seq
);

  localparam logic [5:0] FULL_CNT = 6'(WORD_BITS);
  localparam logic [5:0] MAX_CNT  = 6'd63;

  function automatic logic is_onehot8(input logic [7:0] a);
    return (a != 8'h00) && ((a & (a - 8'd1)) == 8'h00);
  endfunction

  // Anode bit for row k sits at sr[7-k].
  function automatic logic [2:0] anode_row(input logic [7:0] a);
    logic [2:0] r;
    case (a)
      8'h80:   r = 3'd0;
      8'h40:   r = 3'd1;
      8'h20:   r = 3'd2;
      8'h10:   r = 3'd3;
      8'h08:   r = 3'd4;
      8'h04:   r = 3'd5;
      8'h02:   r = 3'd6;
      8'h01:   r = 3'd7;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] latch_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   clk_hist_r;
  logic                   latch_hist_r;
  logic [31:0]            sr_r;
  logic [5:0]             bit_cnt_r;
  logic [23:0]            fb_r [8];
  logic                   prev_valid_r;
  logic [2:0]             prev_row_r;

  logic        clk_syn_s;
  logic        latch_syn_s;
  logic        mosi_syn_s;
  logic        clk_rise_s;
  logic        latch_rise_s;
  logic [7:0]  anode_s;
  logic [23:0] colour_s;
  logic [2:0]  row_s;
  logic        word_ok_s;
  logic        clear_word_s;
  logic        blank_s;
  logic        onehot_s;
  logic        seq_bad_s;
  logic        new_bc_err_s;
  logic        new_oh_err_s;
  logic        new_seq_err_s;

  // Synchronisers run through reset so history can load a settled value.
  always_ff @(posedge clk_25mhz) begin
    clk_sync_r   <= {clk_sync_r[SYNC_STAGES-2:0], matrix_clk};
    latch_sync_r <= {latch_sync_r[SYNC_STAGES-2:0], matrix_latch};
    mosi_sync_r  <= {mosi_sync_r[SYNC_STAGES-2:0], matrix_mosi};
  end

  // Edge detection and decode of the word currently held in the shift register.
  always_comb begin
    clk_syn_s     = clk_sync_r[SYNC_STAGES-1];
    latch_syn_s   = latch_sync_r[SYNC_STAGES-1];
    mosi_syn_s    = mosi_sync_r[SYNC_STAGES-1];
    clk_rise_s    = clk_syn_s & ~clk_hist_r;
    latch_rise_s  = latch_syn_s & ~latch_hist_r;
    anode_s       = sr_r[7:0];
    colour_s      = ~sr_r[31:8];
    row_s         = anode_row(anode_s);
    word_ok_s     = (bit_cnt_r == FULL_CNT);
    clear_word_s  = (sr_r == 32'hFFFF_FFFF);
    blank_s       = (anode_s == 8'h00);
    onehot_s      = is_onehot8(anode_s);
    seq_bad_s     = prev_valid_r && (row_s != (prev_row_r + 3'd1));
    new_bc_err_s  = latch_rise_s && !word_ok_s;
    new_oh_err_s  = latch_rise_s && word_ok_s && !clear_word_s && !blank_s && !onehot_s;
    new_seq_err_s = latch_rise_s && word_ok_s && !clear_word_s && onehot_s && seq_bad_s;
  end

  // Shift, latch, frame-buffer update and sticky error flags.
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      clk_hist_r     <= clk_syn_s;
      latch_hist_r   <= latch_syn_s;
      sr_r           <= 32'h0000_0000;
      bit_cnt_r      <= 6'd0;
      prev_valid_r   <= 1'b0;
      prev_row_r     <= 3'd0;
      fb_rd_data     <= 24'h00_0000;
      latch_word     <= 32'h0000_0000;
      word_valid     <= 1'b0;
      row_index      <= 3'd0;
      frame_done     <= 1'b0;
      err_bit_count  <= 1'b0;
      err_row_onehot <= 1'b0;
      err_row_seq    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        fb_r[i] <= 24'h00_0000;
      end
    end else begin
      clk_hist_r   <= clk_syn_s;
      latch_hist_r <= latch_syn_s;
      word_valid   <= latch_rise_s;
      frame_done   <= 1'b0;
      fb_rd_data   <= fb_r[fb_rd_row];

      if (clk_rise_s) begin
        sr_r <= {sr_r[30:0], mosi_syn_s};
      end

      // A clock edge landing with the latch starts the next word.
      if (latch_rise_s) begin
        bit_cnt_r <= clk_rise_s ? 6'd1 : 6'd0;
      end else if (clk_rise_s && (bit_cnt_r != MAX_CNT)) begin
        bit_cnt_r <= bit_cnt_r + 6'd1;
      end

      if (latch_rise_s) begin
        latch_word <= sr_r;
        if (word_ok_s && clear_word_s) begin
          prev_valid_r <= 1'b0;
          for (int i = 0; i < 8; i++) begin
            fb_r[i] <= 24'h00_0000;
          end
        end else if (word_ok_s && onehot_s) begin
          fb_r[row_s]  <= colour_s;
          row_index    <= row_s;
          prev_valid_r <= 1'b1;
          prev_row_r   <= row_s;
          frame_done   <= (row_s == 3'd7);
        end
      end

      err_bit_count  <= new_bc_err_s  | (err_bit_count  & ~err_clr);
      err_row_onehot <= new_oh_err_s  | (err_row_onehot & ~err_clr);
      err_row_seq    <= new_seq_err_s | (err_row_seq    & ~err_clr);
    end
  end

endmodule

// File: tb/tb_matrix_rx.sv
// Self-checking bench for matrix_rx: serial driver tasks, a word-level reference model
// and one compare process that checks the outputs whenever the line is idle.
module tb_matrix_rx;

  logic        clk_25mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        matrix_clk = 1'b0;
  logic        matrix_latch = 1'b0;
  logic        matrix_mosi = 1'b0;
  logic        err_clr = 1'b0;
  logic [2:0]  fb_rd_row = 3'd0;
  logic [23:0] fb_rd_data;
  logic [31:0] latch_word;
  logic        word_valid;
  logic [2:0]  row_index;
  logic        frame_done;
  logic        err_bit_count;
  logic        err_row_onehot;
  logic        err_row_seq;

  always #20 clk_25mhz = ~clk_25mhz;

  matrix_rx #(.SYNC_STAGES(2), .WORD_BITS(32)) dut (
    .clk_25mhz(clk_25mhz), .rst_n(rst_n), .matrix_clk(matrix_clk),
    .matrix_latch(matrix_latch), .matrix_mosi(matrix_mosi), .err_clr(err_clr),
    .fb_rd_row(fb_rd_row), .fb_rd_data(fb_rd_data), .latch_word(latch_word),
    .word_valid(word_valid), .row_index(row_index), .frame_done(frame_done),
    .err_bit_count(err_bit_count), .err_row_onehot(err_row_onehot), .err_row_seq(err_row_seq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  bit          bits_q[$];
  int          m_cnt = 0;
  logic [23:0] m_fb [8];
  int          m_prev = -1;
  logic [31:0] m_word = 32'h0;
  logic [2:0]  m_row = 3'd0;
  logic        m_ebc = 1'b0, m_eoh = 1'b0, m_eseq = 1'b0;
  int          m_words = 0, m_frames = 0;

  function automatic logic [31:0] model_sr();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) begin
      int idx;
      idx = bits_q.size() - 1 - i;
      w[i] = (idx >= 0) ? bits_q[idx] : 1'b0;
    end
    return w;
  endfunction

  function automatic void model_reset();
    bits_q.delete();
    m_cnt = 0; m_prev = -1; m_word = 32'h0; m_row = 3'd0;
    m_ebc = 1'b0; m_eoh = 1'b0; m_eseq = 1'b0;
    for (int i = 0; i < 8; i++) m_fb[i] = 24'h0;
  endfunction

  function automatic void model_bit(bit b);
    bits_q.push_back(b);
    if (m_cnt < 63) m_cnt++;
  endfunction

  function automatic void model_latch();
    logic [31:0] w;
    logic [7:0]  anode, red, blue, green;
    int          k;
    w = model_sr();
    m_word = w;
    m_words++;
    anode = w[7:0];
    if (m_cnt != 32) begin
      m_ebc = 1'b1;
    end else if (w == 32'hFFFF_FFFF) begin
      for (int i = 0; i < 8; i++) m_fb[i] = 24'h0;
      m_prev = -1;
    end else if (anode == 8'h00) begin
      k = 0;
    end else if ($countones(anode) == 1) begin
      k = 0;
      for (int r = 0; r < 8; r++) if (w[7-r]) k = r;
      // column c of each colour, inverted from the wire, stored at bit 7-c
      for (int c = 0; c < 8; c++) begin
        red[7-c]   = ~w[31-c];
        blue[7-c]  = ~w[23-c];
        green[7-c] = ~w[15-c];
      end
      m_fb[k] = {red, blue, green};
      if (m_prev >= 0 && k != (m_prev + 1) % 8) m_eseq = 1'b1;
      m_prev = k;
      m_row = 3'(k);
      if (k == 7) m_frames++;
    end else begin
      m_eoh = 1'b1;
    end
    m_cnt = 0;
  endfunction

  // ---------------- compare process ----------------
  bit         quiet = 1'b0;
  bit         quiet_q = 1'b0;
  logic [2:0] rd_row_q = 3'd0;
  logic       wv_prev = 1'b0;
  int         n_wv = 0, n_fd = 0;

  always @(posedge clk_25mhz) begin
    rd_row_q <= fb_rd_row;
    quiet_q  <= quiet;
  end

  always @(negedge clk_25mhz) begin
    if (word_valid) begin
      n_wv++;
      check("word_valid_width", {31'h0, wv_prev}, 32'h0);
    end
    if (frame_done) begin
      n_fd++;
      check("frame_done_with_valid", {31'h0, word_valid}, 32'h1);
    end
    wv_prev = word_valid;
    if (quiet && quiet_q && rst_n) begin
      check("latch_word", latch_word, m_word);
      check("row_index", {29'h0, row_index}, {29'h0, m_row});
      check("err_bit_count", {31'h0, err_bit_count}, {31'h0, m_ebc});
      check("err_row_onehot", {31'h0, err_row_onehot}, {31'h0, m_eoh});
      check("err_row_seq", {31'h0, err_row_seq}, {31'h0, m_eseq});
      check("word_valid_count", n_wv, m_words);
      check("frame_done_count", n_fd, m_frames);
      check("fb_rd_data", {8'h0, fb_rd_data}, {8'h0, m_fb[rd_row_q]});
    end
  end

  initial begin
    forever begin
      @(negedge clk_25mhz);
      fb_rd_row = fb_rd_row + 3'd1;
    end
  end

  initial begin
    #3600000;
    $display("FAIL watchdog: actual timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic send_bit(bit b, int hi, int lo);
    quiet = 1'b0;
    matrix_clk = 1'b0;
    matrix_mosi = b;
    cyc(lo);
    matrix_clk = 1'b1;
    model_bit(b);
    cyc(hi);
  endtask

  task automatic send_latch();
    quiet = 1'b0;
    matrix_clk = 1'b0;
    cyc(2);
    matrix_latch = 1'b1;
    model_latch();
    cyc(2);
    matrix_latch = 1'b0;
    cyc(2);
  endtask

  task automatic send_bits(logic [31:0] w, int nbits, int hi, int lo);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i], hi, lo);
  endtask

  task automatic send_word(logic [31:0] w, int hi, int lo);
    send_bits(w, 32, hi, lo);
    send_latch();
  endtask

  task automatic settle();
    cyc(6);
    quiet = 1'b1;
    cyc(10);
  endtask

  task automatic pulse_clr();
    quiet = 1'b0;
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    m_ebc = 1'b0; m_eoh = 1'b0; m_eseq = 1'b0;
    cyc(2);
    quiet = 1'b1;
    cyc(4);
  endtask

  function automatic logic [31:0] row_word(logic [23:0] wire_col, int k);
    logic [7:0] a;
    a = 8'h80 >> k;
    return {wire_col, a};
  endfunction

  initial begin
    int base_fd, base_wv, row, kind, hi, lo;
    logic [31:0] w;
    model_reset();
    rst_n = 1'b0;
    cyc(5);
    rst_n = 1'b1;
    cyc(2);
    check("reset_latch_word", latch_word, 32'h0);
    check("reset_word_valid", {31'h0, word_valid}, 32'h0);
    check("reset_errs", {29'h0, err_bit_count, err_row_onehot, err_row_seq}, 32'h0);
    settle();

    // clear word
    send_word(32'hFFFF_FFFF, 2, 2);
    settle();
    check("clear_latch_word", latch_word, 32'hFFFF_FFFF);
    check("clear_no_err", {29'h0, err_bit_count, err_row_onehot, err_row_seq}, 32'h0);

    // row write: red AA on the wire, blue/green off, row 2
    send_word(32'hAAFF_FF20, 2, 2);
    settle();
    check("lit_model_fb2", {8'h0, m_fb[2]}, 32'h0055_0000);
    check("row_write_index", {29'h0, row_index}, 32'h2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_25mhz);
      if (rd_row_q == 3'd2) break;
    end
    check("row_write_fb2", {8'h0, fb_rd_data}, 32'h0055_0000);

    // row sequence 0..7 then an out-of-order row
    send_word(32'hFFFF_FFFF, 2, 2);
    settle();
    base_fd = n_fd;
    for (int k = 0; k < 8; k++) send_word(row_word(24'($urandom), k), 2, 2);
    settle();
    check("seq_frame_done_once", n_fd - base_fd, 32'd1);
    check("seq_no_err", {31'h0, err_row_seq}, 32'h0);
    send_word(row_word(24'h123456, 3), 2, 2);
    settle();
    check("seq_err_set", {31'h0, err_row_seq}, 32'h1);
    pulse_clr();
    check("seq_err_clr", {31'h0, err_row_seq}, 32'h0);

    // short word
    base_wv = n_wv;
    send_bits(32'($urandom), 31, 2, 2);
    send_latch();
    settle();
    check("count_err_set", {31'h0, err_bit_count}, 32'h1);
    check("count_err_valid", n_wv - base_wv, 32'd1);
    pulse_clr();

    // bad anode, then blank anode
    send_word(32'h0F0F_0F81, 2, 2);
    settle();
    check("onehot_err_set", {31'h0, err_row_onehot}, 32'h1);
    pulse_clr();
    send_word(32'h0000_0000, 2, 2);
    settle();
    check("blank_no_err", {31'h0, err_row_onehot}, 32'h0);

    // reset in mid-word, then a full row-0 word
    send_bits(32'($urandom), 10, 2, 2);
    matrix_clk = 1'b0;
    cyc(4);
    rst_n = 1'b0;
    model_reset();
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    send_word(row_word(24'hA5C33C, 0), 2, 2);
    settle();
    check("post_reset_no_bc_err", {31'h0, err_bit_count}, 32'h0);
    check("post_reset_row", {29'h0, row_index}, 32'h0);

    // latch and a clock edge in the same cycle: that bit opens the next word
    w = row_word(24'h0F1E2D, 1);
    send_bits(row_word(24'h778899, 0), 32, 2, 2);
    matrix_clk = 1'b0;
    matrix_mosi = w[31];
    cyc(2);
    matrix_clk = 1'b1;
    matrix_latch = 1'b1;
    model_latch();
    model_bit(w[31]);
    cyc(2);
    matrix_clk = 1'b0;
    matrix_latch = 1'b0;
    cyc(2);
    send_bits(w, 31, 2, 2);
    send_latch();
    settle();
    check("coincident_row", {29'h0, row_index}, 32'h1);

    // randomized traffic
    row = 2;
    for (int n = 0; n < 110; n++) begin
      hi = $urandom_range(4, 2);
      lo = $urandom_range(4, 2);
      kind = $urandom_range(99, 0);
      if (kind < 70) begin
        row = ($urandom_range(9, 0) < 8) ? (row + 1) % 8 : $urandom_range(7, 0);
        send_word(row_word(24'($urandom), row), hi, lo);
      end else if (kind < 78) begin
        send_word({24'($urandom), 8'h00}, hi, lo);
      end else if (kind < 86) begin
        w = {24'($urandom), 8'($urandom)};
        send_word(w, hi, lo);
      end else if (kind < 94) begin
        send_bits(32'($urandom), $urandom_range(34, 28), hi, lo);
        send_latch();
      end else begin
        send_word(32'hFFFF_FFFF, hi, lo);
      end
      settle();
      if ($urandom_range(7, 0) == 0) pulse_clr();
    end

    quiet = 1'b0;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
